// File: rtl/cipher_ram_sequencer.sv
// cipher_ram_sequencer: moves the key, input blocks and results between three
// byte-wide RAMs and a 64-bit-block / 128-bit-key cipher core.
// Optional core_done watchdog is built when CIPHER_SEQ_WDOG_EN is defined.
module cipher_ram_sequencer #(
    parameter logic [7:0] IN_BASE     = 8'h00,
    parameter logic [7:0] OUT_BASE    = 8'h00,
    parameter logic [7:0] KEY_BASE    = 8'h00,
    parameter int         WDOG_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   num_blocks,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   key_addr,
    input  logic [7:0]   key_dout,
    output logic [7:0]   in_addr,
    input  logic [7:0]   in_dout,
    output logic [7:0]   out_addr,
    output logic         out_we,
    output logic [7:0]   out_din,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [63:0]  core_block_in,
    input  logic         core_done,
    input  logic [63:0]  core_block_out
);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_BLK, RUN, WAIT, STORE, FIN} state_t;

    state_t           state, state_nx;
    logic [4:0]       cnt;
    logic [7:0]       blk, nblk;
    logic [15:0][7:0] key_r;   // key byte i lives in key_r[15-i]
    logic [7:0][7:0]  blk_r;   // block byte i lives in blk_r[7-i]
    logic [7:0][7:0]  res_r;
    logic [7:0]       boff;
    logic             accept;
    logic             wdog_trip;

    assign accept        = (state == IDLE) && start;
    assign boff          = {blk[4:0], 3'b000};
    assign core_key      = key_r;
    assign core_block_in = blk_r;

`ifdef CIPHER_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wcnt;
    logic            err_r;

    // A missing core_done is only declared once the full window has elapsed
    assign wdog_trip = (state == WAIT) && !core_done && (wcnt == WD_W'(WDOG_CYCLES - 1));
    assign err       = err_r;

    // Watchdog counter counts WAIT cycles; sticky error cleared by a new job
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt  <= '0;
            err_r <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (accept)
                err_r <= 1'b0;
            else if (wdog_trip)
                err_r <= 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nx   = state;
        busy       = (state != IDLE) && (state != FIN);
        done       = (state == FIN);
        core_start = (state == RUN);
        out_we     = 1'b0;
        out_din    = 8'h00;
        key_addr   = 8'h00;
        in_addr    = 8'h00;
        out_addr   = 8'h00;
        case (state)
            IDLE: if (start) state_nx = (num_blocks == 8'd0) ? FIN : LOAD_KEY;
            LOAD_KEY: begin
                if (cnt < 5'd16) key_addr = KEY_BASE + {3'b000, cnt};
                if (cnt == 5'd16) state_nx = LOAD_BLK;
            end
            LOAD_BLK: begin
                if (cnt < 5'd8) in_addr = IN_BASE + boff + {3'b000, cnt};
                if (cnt == 5'd8) state_nx = RUN;
            end
            RUN: state_nx = WAIT;
            WAIT: begin
                if (core_done)      state_nx = STORE;
                else if (wdog_trip) state_nx = FIN;
            end
            STORE: begin
                out_we   = 1'b1;
                out_addr = OUT_BASE + boff + {3'b000, cnt};
                out_din  = res_r[3'(5'd7 - cnt)];
                if (cnt == 5'd7)
                    state_nx = (8'(blk + 8'd1) == nblk) ? FIN : LOAD_BLK;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase counter restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n || state_nx != state) cnt <= '0;
        else                             cnt <= cnt + 1'b1;
    end

    // Job bookkeeping and data capture (RAM data arrives one cycle after address)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk   <= '0;
            nblk  <= '0;
            key_r <= '0;
            blk_r <= '0;
            res_r <= '0;
        end else begin
            if (accept) begin
                nblk <= num_blocks;
                blk  <= '0;
            end
            if (state == LOAD_KEY && cnt != 5'd0)
                key_r[4'(5'd16 - cnt)] <= key_dout;
            if (state == LOAD_BLK && cnt != 5'd0)
                blk_r[3'(5'd8 - cnt)] <= in_dout;
            if (state == WAIT && core_done)
                res_r <= core_block_out;
            if (state == STORE && cnt == 5'd7)
                blk <= blk + 8'd1;
        end
    end

endmodule

// File: doc/cipher_ram_sequencer.md
Name: cipher_ram_sequencer

Overview:
- Sequences the byte-wide single-port RAMs around the 64-bit-block / 128-bit-key cipher core.
- On a host start, it reads the 16-byte key once from the key RAM, then for each block:
  - reads 8 bytes from the input RAM,
  - runs the core with a start/done handshake,
  - writes the 8-byte result to the output RAM.
- Sits between the host control registers and the three RAM instances (key, input, output).

Parameters:
- IN_BASE, 8'h00, input RAM byte address of block 0
- OUT_BASE, 8'h00, output RAM byte address of block 0
- KEY_BASE, 8'h00, key RAM address of key byte 0
- WDOG_CYCLES, 1024, core_done timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  host request; sampled in IDLE only
- num_blocks  in  8  number of 8-byte blocks; latched on accepted start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky watchdog error; cleared on next accepted start
- key_addr  out  8  key RAM address
- key_dout  in  8  key RAM read data (1-cycle read latency)
- in_addr  out  8  input RAM address
- in_dout  in  8  input RAM read data (1-cycle read latency)
- out_addr  out  8  output RAM address
- out_we  out  1  output RAM write enable
- out_din  out  8  output RAM write data
- core_start  out  1  one-cycle pulse to the cipher core
- core_key  out  128  key register; byte 0 maps to [127:120]
- core_block_in  out  64  block register; byte 0 maps to [63:56]
- core_done  in  1  core completion pulse
- core_block_out  in  64  core result; valid in the core_done cycle

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - busy, done, err, out_we and core_start = 0.
  - All addresses = 0; key/block/result registers = 0.
  - Reset mid-job aborts immediately; no further RAM writes occur.
- Address arithmetic is 8-bit and wraps modulo 256.
  - Block b, byte i input address = IN_BASE + 8*b + i.
  - Output address uses the same form with OUT_BASE.
- RAM reads have a 1-cycle latency: data for an address driven in cycle n is captured in cycle n+1.
- IDLE:
  - start=1 latches num_blocks, clears err, sets block counter b=0.
  - If num_blocks=0: go to FIN (no RAM or core activity). Otherwise go to LOAD_KEY.
- LOAD_KEY: KEY_BYTES+1 = 17 cycles, using counter c=0..16.
  - key_addr = KEY_BASE+c for c<16.
  - For c>=1, key_dout is captured into key byte c-1.
  - Then go to LOAD_BLK.
- LOAD_BLK: 9 cycles, same scheme.
  - in_addr = block byte c for c<8; capture byte c-1 for c>=1.
  - Then go to RUN.
- RUN: 1 cycle.
  - core_start=1; core_key and core_block_in are stable from this cycle until core_done.
  - Then go to WAIT.
- WAIT:
  - On core_done=1, latch core_block_out into the result register and go to STORE.
  - core_done outside WAIT is ignored.
- STORE: 8 cycles.
  - out_we=1; out_addr = output byte c; out_din = result byte c (byte 0 = [63:56]).
  - Then b++. If b==num_blocks go to FIN, else go to LOAD_BLK. The key is not reloaded.
- FIN: done=1 for one cycle; busy=0 in the same cycle; then go to IDLE.
- start while busy (any state other than IDLE) is ignored.
- start asserted in the FIN cycle is ignored; it is accepted in IDLE on the next cycle if still high.
- Per-job latency, for core latency L (cycles from core_start to core_done):
  - 1 + 17 + num_blocks*(9 + 1 + L + 8) + 1.
- out_we is never high outside STORE.

Optional Feature:
- Macro: CIPHER_SEQ_WDOG_EN.
- With the macro defined:
  - A counter runs in WAIT.
  - If core_done is not seen within WDOG_CYCLES cycles: err=1, go to FIN (done pulses), and skip the remaining blocks with no writes.
- Without the macro: err is tied 0, and WAIT waits indefinitely.

Test Plan:
- Basic job:
  - Stimulus: key RAM 00..0F; input RAM 11 22 33 44 55 66 77 88; model core returns block XOR key[127:64] after L=4 cycles; num_blocks=1, start.
  - Required: output RAM[0..7] = 11 23 31 47 51 63 71 8F; done exactly 1+17+22+1 = 41 cycles after the start edge; err=0.
- Multi-block with wrap:
  - Stimulus: IN_BASE=OUT_BASE=8'hFC, num_blocks=2.
  - Required: addresses FC..FF, 00..0B are used in order; the key is read only once (17 key-RAM accesses total).
- num_blocks=0:
  - Required: done pulses 2 cycles after start; no out_we, no core_start, no in_addr activity.
- Start while busy and mid-job reset:
  - Stimulus: start re-pulsed during WAIT, then rst_n=0 during STORE c=3.
  - Required: the second start has no effect; after reset, out_we=0 and busy=0 next cycle; bytes 4..7 are not written.
- Watchdog (CIPHER_SEQ_WDOG_EN, WDOG_CYCLES=16):
  - Stimulus: core never asserts done.
  - Required: err=1 and a done pulse after 16 WAIT cycles; no writes; err clears on the next start.
- Spurious core_done:
  - Stimulus: core_done pulsed during LOAD_BLK.
  - Required: ignored; the sequence and results are unchanged.
